writeback_queue: RTL and testbench

//   Buffers register write requests from the writeback stage and drains them, one per

---
 rtl/writeback_queue_if.sv | 14 +
 rtl/writeback_queue.sv | 89 ++++++++
 tb/tb_writeback_queue.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
// Writeback-stage request channel into writeback_queue: a valid/ready handshake
// carrying a destination register address and its data.
interface writeback_queue_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          WbValid;
   logic          WbReady;
   logic [AW-1:0] WbRegister;
   logic [DW-1:0] WbData;

   modport master (output WbValid, WbRegister, WbData, input WbReady);
   modport slave  (input WbValid, WbRegister, WbData, output WbReady);
endinterface

// File: rtl/writeback_queue.sv
// In-order write buffer in front of the 32x32 regfile write port. It drains one entry
// per cycle and forwards still-pending writes onto both operand read ports.
module writeback_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     Clk,
   input  logic                     Reset,
   writeback_queue_if.slave         wb,
   input  logic                     DrainHold,
   output logic [AW-1:0]            WriteRegister,
   output logic [DW-1:0]            WriteData,
   output logic                     RegWrite,
   input  logic [AW-1:0]            ReadRegister1,
   input  logic [AW-1:0]            ReadRegister2,
   input  logic [DW-1:0]            ReadData1,
   input  logic [DW-1:0]            ReadData2,
   output logic [DW-1:0]            Operand1,
   output logic [DW-1:0]            Operand2,
   output logic [$clog2(DEPTH):0]   Count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_addr [DEPTH];
   logic [DW-1:0] r_data [DEPTH];

   logic          w_not_empty;
   logic          w_enq_stored;
   logic          w_drain;
   logic [PW-1:0] w_idx;
   logic [DW-1:0] w_op1;
   logic [DW-1:0] w_op2;

   // Held low during reset so no handshake can complete while requests are discarded.
   assign wb.WbReady   = ~Reset & (r_count != CW'(DEPTH));
   assign w_not_empty  = (r_count != '0);
   assign w_drain      = w_not_empty & ~DrainHold;
   assign w_enq_stored = wb.WbValid & wb.WbReady & (wb.WbRegister != '0);

   assign RegWrite      = w_drain;
   assign WriteRegister = w_not_empty ? r_addr[r_head] : '0;
   assign WriteData     = w_not_empty ? r_data[r_head] : '0;
   assign Count         = r_count;
   assign Operand1      = w_op1;
   assign Operand2      = w_op2;

   // NOTE: sequential state uses <= so every register samples pre-edge values together.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq_stored) r_tail <= r_tail + PW'(1);
         if (w_drain)      r_head <= r_head + PW'(1);
         r_count <= r_count + CW'(w_enq_stored) - CW'(w_drain);
      end
   end

   // NOTE: the payload array has no reset; occupancy alone decides which slots are valid.
   always_ff @(posedge Clk) begin
      if (w_enq_stored) begin
         r_addr[r_tail] <= wb.WbRegister;
         r_data[r_tail] <= wb.WbData;
      end
   end

   // Walk oldest to youngest so the last hit is the most recently enqueued write.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_op1 = ReadData1;
      w_op2 = ReadData2;
      w_idx = r_head;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_head + PW'(k);
         if (CW'(k) < r_count) begin
            if (r_addr[w_idx] == ReadRegister1) w_op1 = r_data[w_idx];
            if (r_addr[w_idx] == ReadRegister2) w_op2 = r_data[w_idx];
         end
      end
      if (ReadRegister1 == '0) w_op1 = '0;
      if (ReadRegister2 == '0) w_op2 = '0;
   end
endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed table, multi-cycle corner sequences
// and randomized traffic against a queue-based reference model and a regfile model.
module tb_writeback_queue;
   localparam int DEPTH = 4;

   typedef struct {
      logic        valid;
      logic [4:0]  wreg;
      logic [31:0] data;
      logic        hold;
      logic [4:0]  rr1;
      logic [4:0]  rr2;
      logic        e_ready;
      logic        e_rw;
      logic [4:0]  e_wreg;
      logic [31:0] e_wdata;
      logic [2:0]  e_cnt;
      logic [31:0] e_op1;
      logic [31:0] e_op2;
   } vec_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   logic        Clk;
   logic        Reset;
   logic        DrainHold;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [31:0] Operand1;
   logic [31:0] Operand2;
   logic [2:0]  Count;

   writeback_queue_if #(.AW(5), .DW(32)) wb ();

   writeback_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .wb            (wb),
      .DrainHold     (DrainHold),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .RegWrite      (RegWrite),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .Operand1      (Operand1),
      .Operand2      (Operand2),
      .Count         (Count)
   );

   // Regfile model: combinational read, written from the DUT's write port.
   logic [31:0] rf [32];
   assign ReadData1 = rf[ReadRegister1];
   assign ReadData2 = rf[ReadRegister2];

   // Reference model: pending writes, oldest at index 0.
   ent_t m_q[$];

   int n_checks = 0;
   int n_errors = 0;

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_operand(input logic [4:0] rr, input logic [31:0] rd);
      if (rr == 5'd0) return 32'd0;
      for (int i = m_q.size() - 1; i >= 0; i--)
         if (m_q[i].addr == rr) return m_q[i].data;
      return rd;
   endfunction

   function automatic vec_t mk(input logic valid, input logic [4:0] r, input logic [31:0] d,
                               input logic hold, input logic [4:0] rr1, input logic [4:0] rr2);
      vec_t v;
      v = '{default: '0};
      v.valid = valid;
      v.wreg  = r;
      v.data  = d;
      v.hold  = hold;
      v.rr1   = rr1;
      v.rr2   = rr2;
      return v;
   endfunction

   // Applies one cycle of inputs after the falling edge and checks the settled outputs.
   task automatic drive(input vec_t v, input bit use_tab, input string tag);
      int n;
      @(negedge Clk);
      wb.WbValid    = v.valid;
      wb.WbRegister = v.wreg;
      wb.WbData     = v.data;
      DrainHold     = v.hold;
      ReadRegister1 = v.rr1;
      ReadRegister2 = v.rr2;
      #1;
      if (use_tab) begin
         check({tag, ".ready"}, 32'(wb.WbReady),   32'(v.e_ready));
         check({tag, ".rw"},    32'(RegWrite),     32'(v.e_rw));
         check({tag, ".wreg"},  32'(WriteRegister), 32'(v.e_wreg));
         check({tag, ".wdata"}, WriteData,          v.e_wdata);
         check({tag, ".count"}, 32'(Count),        32'(v.e_cnt));
         check({tag, ".op1"},   Operand1,           v.e_op1);
         check({tag, ".op2"},   Operand2,           v.e_op2);
      end else begin
         n = m_q.size();
         check({tag, ".ready"}, 32'(wb.WbReady),    32'(n != DEPTH));
         check({tag, ".rw"},    32'(RegWrite),      32'(n != 0 && !v.hold));
         check({tag, ".wreg"},  32'(WriteRegister), (n != 0) ? 32'(m_q[0].addr) : 32'd0);
         check({tag, ".wdata"}, WriteData,          (n != 0) ? m_q[0].data : 32'd0);
         check({tag, ".count"}, 32'(Count),         32'(n));
         check({tag, ".op1"},   Operand1,           m_operand(v.rr1, rf[v.rr1]));
         check({tag, ".op2"},   Operand2,           m_operand(v.rr2, rf[v.rr2]));
      end
   endtask

   // Crosses the rising edge: the regfile commits what the DUT offered, the model steps.
   task automatic advance();
      logic        do_drain;
      logic        do_enq;
      ent_t        e;
      logic        rw;
      logic [4:0]  wa;
      logic [31:0] wd;
      do_drain = (m_q.size() != 0) && !DrainHold;
      do_enq   = wb.WbValid && (m_q.size() != DEPTH) && (wb.WbRegister != 5'd0);
      e        = '{wb.WbRegister, wb.WbData};
      rw       = RegWrite;
      wa       = WriteRegister;
      wd       = WriteData;
      @(posedge Clk);
      if (rw === 1'b1 && wa != 5'd0) rf[wa] = wd;
      if (do_drain) void'(m_q.pop_front());
      if (do_enq) m_q.push_back(e);
   endtask

   vec_t tab [11];
   vec_t v;
   int   t3_addr [5];

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      Reset = 1'b1;
      wb.WbValid = 1'b0; wb.WbRegister = 5'd0; wb.WbData = 32'd0;
      DrainHold = 1'b0; ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
      #3;
      check("reset.rw",    32'(RegWrite), 32'd0);
      check("reset.count", 32'(Count),    32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      check("reset.ready", 32'(wb.WbReady), 32'd1);

      // valid reg data hold rr1 rr2 | ready rw wreg wdata count op1 op2
      tab[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'h0,        32'h0};
      tab[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 3'd1, 32'hDEADBEEF, 32'hDEADBEEF};
      tab[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'hDEADBEEF, 32'h0};
      tab[3]  = '{1'b1, 5'd7, 32'h1,        1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'h0,        32'h0};
      tab[4]  = '{1'b1, 5'd7, 32'h2,        1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 32'h1,        3'd1, 32'h1,        32'h1};
      tab[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 32'h1,        3'd2, 32'h2,        32'h2};
      tab[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 32'h1,        3'd2, 32'h2,        32'h2};
      tab[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 32'h2,        3'd1, 32'h2,        32'h2};
      tab[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'h2,        32'h2};
      tab[9]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'h0,        32'h2};
      tab[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'h0,        32'h0};
      for (int i = 0; i < 11; i++) begin
         drive(tab[i], 1'b1, $sformatf("tab%0d", i));
         advance();
      end
      check("t1.rf5", rf[5], 32'hDEADBEEF);
      check("t2.rf7", rf[7], 32'h2);

      // Fill under hold, stall a fifth request, then drain with it still presented.
      for (int i = 1; i <= 4; i++) begin
         drive(mk(1'b1, 5'(i), 32'(32'h300 + i), 1'b1, 5'(i), 5'd0), 1'b0, "t3.fill");
         advance();
      end
      drive(mk(1'b1, 5'd6, 32'd9, 1'b1, 5'd4, 5'd6), 1'b0, "t3.stall");
      check("t3.full_ready", 32'(wb.WbReady), 32'd0);
      check("t3.full_count", 32'(Count), 32'd4);
      advance();
      t3_addr = '{1, 2, 3, 4, 6};
      for (int i = 0; i < 5; i++) begin
         drive(mk(i < 2, 5'd6, 32'd9, 1'b0, 5'd0, 5'd0), 1'b0, "t3.drain");
         check($sformatf("t3.rw%0d", i),   32'(RegWrite), 32'd1);
         check($sformatf("t3.wreg%0d", i), 32'(WriteRegister), 32'(t3_addr[i]));
         check($sformatf("t3.ready%0d", i), 32'(wb.WbReady), (i == 0) ? 32'd0 : 32'd1);
         advance();
      end
      drive(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd6, 5'd4), 1'b0, "t3.idle");
      advance();
      for (int i = 1; i <= 4; i++) check($sformatf("t3.rf%0d", i), rf[i], 32'(32'h300 + i));
      check("t3.rf6", rf[6], 32'd9);

      // Back-to-back enqueue with no hold: occupancy stays at one.
      for (int i = 0; i < 8; i++) begin
         drive(mk(1'b1, 5'(8 + i), 32'(8 + i), 1'b0, 5'(8 + i), 5'd0), 1'b0, "t5");
         check("t5.ready", 32'(wb.WbReady), 32'd1);
         check("t5.count", 32'(Count), (i == 0) ? 32'd0 : 32'd1);
         advance();
      end
      drive(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0), 1'b0, "t5.idle");
      advance();
      for (int i = 8; i <= 15; i++) check($sformatf("t5.rf%0d", i), rf[i], 32'(i));

      // Reset pulse between edges with three writes pending.
      for (int i = 0; i < 3; i++) begin
         drive(mk(1'b1, 5'(9 + i), 32'(32'hA0 + i), 1'b1, 5'd0, 5'd0), 1'b0, "t6.fill");
         advance();
      end
      drive(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd11), 1'b0, "t6.pend");
      DrainHold = 1'b0;
      #1;
      check("t6.rw_before", 32'(RegWrite), 32'd1);
      Reset = 1'b1;
      #1;
      check("t6.rw_reset",    32'(RegWrite), 32'd0);
      check("t6.count_reset", 32'(Count), 32'd0);
      check("t6.op1_reset",   Operand1, 32'd9);
      check("t6.op2_reset",   Operand2, 32'd11);
      Reset = 1'b0;
      m_q.delete();
      #1;
      advance();
      drive(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd11), 1'b0, "t6.after");
      advance();
      for (int i = 9; i <= 11; i++) check($sformatf("t6.rf%0d", i), rf[i], 32'(i));

      // Randomized traffic on a small register window to force collisions and fills.
      for (int c = 0; c < 400; c++) begin
         v = mk($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         drive(v, 1'b0, "rand");
         advance();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
